// File: rtl/filter_sample_capture.sv
// -----------------------------------------------------------------------------
// filter_sample_capture
//   Capture buffer on the output side of the biquad filter. Records a window
//   of DEPTH samples around a signed level-crossing trigger, PRE of them taken
//   before the trigger, and plays the window back oldest-first through a
//   one-sample read port with one cycle of latency.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high; aborts any capture or readout
//   in_valid   in_sample carries a new filter output this cycle
//   in_sample  signed filter output sample
//   arm        one-cycle pulse starting a capture (honoured only in IDLE)
//   trig_level signed trigger threshold, sampled every cycle
//   rd_en      request the next window sample (honoured only in DONE)
//   rd_data    registered read sample; holds its value between reads
//   rd_valid   single-cycle pulse marking rd_data as a fresh read result
//   busy       high while capturing (PRETRIG, ARMED, POST)
//   done       high while a complete window is waiting to be read (DONE)
// -----------------------------------------------------------------------------
module filter_sample_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PRE    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     arm,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE;  // post samples, trigger included

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            cnt_q, cnt_d;       // PRETRIG fill / POST count
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            rd_cnt_q, rd_cnt_d;
  logic signed [DATA_W-1:0] prev_sample_q, prev_sample_d;
  logic                     prev_valid_q, prev_valid_d;
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;

  logic                     wr_en;
  logic                     capturing;
  logic                     trig_hit;

  logic signed [DATA_W-1:0] mem [DEPTH];

  assign capturing = (state_q == S_PRETRIG) || (state_q == S_ARMED) ||
                     (state_q == S_POST);

  // Rising crossing: previous sample strictly below the level, current at or
  // above it. All operands are signed.
  assign trig_hit = in_valid && prev_valid_q &&
                    (prev_sample_q < trig_level) && (in_sample >= trig_level);

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    rd_ptr_d      = rd_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    wr_en         = 1'b0;

    // Every valid sample while capturing is stored. The final POST write moves
    // the state to DONE on the same edge, so nothing is written afterwards.
    if (capturing && in_valid) begin
      wr_en         = 1'b1;
      wr_ptr_d      = wr_ptr_q + 1'b1;
      prev_sample_d = in_sample;
      prev_valid_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        wr_ptr_d     = '0;
        cnt_d        = '0;
        rd_cnt_d     = '0;
        prev_valid_d = 1'b0;
        if (arm) state_d = S_PRETRIG;
      end

      S_PRETRIG: begin
        if (in_valid) begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (trig_hit) begin
          // Window start is fixed here: PRE slots behind the trigger address.
          rd_ptr_d = wr_ptr_q - PRE_OFS;
          cnt_d    = AW'(1);
          state_d  = (POST_N == 1) ? S_DONE : S_POST;
        end
      end

      S_POST: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == POST_LAST) state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (rd_en) begin
          rd_data_d  = mem[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          if (rd_cnt_q == RD_LAST) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      rd_cnt_q      <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_cnt_q      <= rd_cnt_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // NOTE: the sample buffer has no reset; its contents are never read before
  // being written in the current capture, and leaving it unreset lets it map
  // onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_sample;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = capturing;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_filter_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_filter_sample_capture
//   Directed bench for filter_sample_capture (DEPTH=16, PRE=4). Expected read
//   data is pushed into a queue just before each readout; a monitor running on
//   the falling edge pops and compares on every rd_valid. Any rd_valid with an
//   empty queue is reported as unexpected.
// -----------------------------------------------------------------------------
module tb_filter_sample_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     arm;
  logic signed [DATA_W-1:0] trig_level;
  logic                     rd_en;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  filter_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .arm        (arm),
    .trig_level (trig_level),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every read result against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 1, 0);
        end else begin
          check("rd_data", int'(rd_data), exp_q.pop_front());
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int s);
    in_valid  = 1'b1;
    in_sample = DATA_W'(s);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Holds rd_en for n cycles; the first read checks the one-cycle latency.
  task automatic read_n(input int n);
    rd_en = 1'b1;
    step();
    check("rd_latency", int'(rd_valid), 1);
    repeat (n - 1) step();
    rd_en = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back(v);
  endtask

  // Capture with trig_level=0 and samples -10..15 back to back; the trigger
  // is 0 (prev -1), the window is -4..11.
  task automatic capture_ramp();
    trig_level = 0;
    arm_pulse();
    check("busy_after_arm", int'(busy), 1);
    for (int s = -10; s <= 15; s++) feed(s);
    check("done_ramp", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
  endtask

  // Crossing 2->8 falls in PRETRIG and must be ignored; 13 and 12 sit above
  // the level; the trigger is the 4->5 crossing. A sample presented together
  // with arm is dropped.
  task automatic capture_no_false();
    int pre_s[8] = '{10, 11, 2, 8, 12, 13, 4, 5};
    trig_level = 5;
    in_valid   = 1'b1;
    in_sample  = 8'sd100;
    arm_pulse();
    in_valid   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(pre_s[i]);
      if (i == 6) check("no_trig_before_5", int'(busy), 1);
    end
    for (int s = 6; s <= 20; s++) feed(s);
    check("done_no_false", int'(done), 1);
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_sample  = '0;
    arm        = 1'b0;
    trig_level = '0;
    rd_en      = 1'b0;

    // ---- reset values ----
    do_reset(2);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // ---- basic window ----
    capture_ramp();
    push_range(-4, 11);
    read_n(DEPTH);
    check("last_rd_valid", int'(rd_valid), 1);
    check("done_after_read", int'(done), 0);
    check("busy_after_read", int'(busy), 0);
    step();
    check("rd_data_hold", int'(rd_data), 11);
    check("rd_valid_drop", int'(rd_valid), 0);

    // ---- ring wrap ----
    trig_level = 50;
    arm_pulse();
    for (int i = 0; i < 40; i++) feed((i % 2 == 0) ? -20 : 20);
    for (int s = 49; s <= 65; s++) feed(s);
    check("done_wrap", int'(done), 1);
    exp_q.push_back(20);
    exp_q.push_back(-20);
    exp_q.push_back(20);
    exp_q.push_back(49);
    push_range(50, 61);
    read_n(DEPTH);
    check("done_after_wrap", int'(done), 0);

    // ---- no false trigger ----
    capture_no_false();
    exp_q.push_back(8);
    exp_q.push_back(12);
    exp_q.push_back(13);
    exp_q.push_back(4);
    push_range(5, 16);
    read_n(DEPTH);

    // ---- gaps and ignored controls ----
    trig_level = 0;
    arm_pulse();
    for (int s = -10; s <= 15; s++) begin
      feed(s);
      if (s == -8) arm = 1'b1;   // re-arm while busy
      if (s == 2)  rd_en = 1'b1; // read request while busy
      step();
      arm   = 1'b0;
      rd_en = 1'b0;
      if (s == 2) check("rd_valid_while_busy", int'(rd_valid), 0);
    end
    check("done_gaps", int'(done), 1);
    push_range(-4, 11);
    read_n(DEPTH);

    // ---- reset during POST ----
    trig_level = 0;
    arm_pulse();
    for (int s = -10; s <= 2; s++) feed(s);
    check("busy_in_post", int'(busy), 1);
    do_reset(1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);
    check("post_rst_rd_valid", int'(rd_valid), 0);
    capture_ramp();
    push_range(-4, 11);
    read_n(DEPTH);

    // ---- reset after 5 reads in DONE ----
    capture_ramp();
    push_range(-4, 0);
    read_n(5);
    do_reset(1);
    check("done_rst_busy", int'(busy), 0);
    check("done_rst_done", int'(done), 0);
    check("done_rst_rd_valid", int'(rd_valid), 0);
    capture_no_false();
    exp_q.push_back(8);
    exp_q.push_back(12);
    exp_q.push_back(13);
    exp_q.push_back(4);
    push_range(5, 16);
    read_n(DEPTH);
    check("done_final", int'(done), 0);

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
